// File: rtl/timer_irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_scheduler
// Brief    : Latches timer overflow/compare pulses as pending bits and hands
//            them one at a time, round-robin, to the event unit.
// Revision : 1.0
// ============================================================================
module timer_irq_scheduler #(
    parameter int TIMER_CNT = 2,
    parameter int ID_W      = ($clog2(2 * TIMER_CNT) < 1) ? 1 : $clog2(2 * TIMER_CNT),
    parameter int MISS_W    = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [2*TIMER_CNT-1:0]   irq_i,
    input  logic [2*TIMER_CNT-1:0]   mask_i,
    input  logic                     clr_pending_i,
    output logic                     evt_valid_o,
    output logic [ID_W-1:0]          evt_id_o,
    input  logic                     evt_ready_i,
    output logic [2*TIMER_CNT-1:0]   pending_o,
    output logic [MISS_W-1:0]        miss_cnt_o
);

    localparam int c_src_cnt = 2 * TIMER_CNT;
    localparam int c_pop_w   = $clog2(c_src_cnt + 1);
    localparam int c_sum_w   = ((MISS_W > c_pop_w) ? MISS_W : c_pop_w) + 1;
    localparam logic [MISS_W-1:0] c_miss_max = {MISS_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_src_cnt-1:0]   r_pending;
    logic                   r_valid;
    logic [ID_W-1:0]        r_id;
    logic [ID_W-1:0]        r_last;
    logic [MISS_W-1:0]      r_miss;

    logic [c_src_cnt-1:0]   w_set;
    logic [c_src_cnt-1:0]   w_elig;
    logic [c_src_cnt-1:0]   w_grant_vec;
    logic [c_src_cnt-1:0]   w_miss_vec;
    logic [c_src_cnt-1:0]   w_pending_nxt;
    logic                   w_found;
    logic                   w_do_grant;
    logic [ID_W-1:0]        w_win;
    logic [c_pop_w-1:0]     w_miss_pop;
    logic [c_sum_w-1:0]     w_miss_sum;
    logic [MISS_W-1:0]      w_miss_nxt;

    assign w_set  = irq_i & mask_i;
    assign w_elig = r_pending & mask_i;

    // Round-robin scan starting just after the last accepted source.
    always_comb begin
        logic [ID_W:0] w_idx;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= c_src_cnt; k++) begin
            w_idx = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(c_src_cnt)) begin
                w_idx = w_idx - (ID_W+1)'(c_src_cnt);
            end
            if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_do_grant = (r_state == S_IDLE) && w_found;

    always_comb begin
        w_grant_vec = '0;
        for (int i = 0; i < c_src_cnt; i++) begin
            w_grant_vec[i] = w_do_grant && (w_win == ID_W'(i));
        end
    end

    // A pulse landing on the bit being granted this cycle re-arms it, not a miss.
    assign w_miss_vec    = w_set & r_pending & ~w_grant_vec;
    assign w_pending_nxt = (clr_pending_i ? '0 : (r_pending & ~w_grant_vec)) | w_set;

    always_comb begin
        w_miss_pop = '0;
        for (int i = 0; i < c_src_cnt; i++) begin
            w_miss_pop = w_miss_pop + c_pop_w'(w_miss_vec[i]);
        end
    end

    assign w_miss_sum = c_sum_w'(r_miss) + c_sum_w'(w_miss_pop);
    assign w_miss_nxt = (w_miss_sum > c_sum_w'(c_miss_max)) ? c_miss_max
                                                            : w_miss_sum[MISS_W-1:0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_last    <= ID_W'(c_src_cnt - 1);
            r_miss    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_miss    <= w_miss_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_valid <= 1'b1;
                        r_id    <= w_win;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (evt_ready_i) begin
                        r_valid <= 1'b0;
                        r_last  <= r_id;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign evt_valid_o = r_valid;
    assign evt_id_o    = r_id;
    assign pending_o   = r_pending;
    assign miss_cnt_o  = r_miss;

endmodule
`default_nettype wire
